// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter/mux slice.
// The arbitration mode is a build-time choice carried as a parameter of rr_arb_mux.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/rr_pick.sv
// First-set picker starting at a programmable index: rotate the request vector so
// 'start' sits at bit 0, find the first set bit, then rotate the result back.
module rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_req
);

    localparam logic [IDX_W:0]    NUM_CH_W = (IDX_W + 1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    // One extra bit on the sum, so the wrap works for channel counts that are not powers of two
    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= NUM_CH_W) begin
            sum = sum - NUM_CH_W;
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [NUM_CH-1:0] rot_s;
    logic [IDX_W-1:0]  off_s;

    // Rotate, priority-encode from the top down so bit 0 wins last, then unrotate
    always_comb begin
        rot_s     = '0;
        off_s     = '0;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        for (int i = 0; i < NUM_CH; i++) begin
            rot_s[i] = req[add_mod(start, IDX_W'(i))];
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IDX_W'(i) : off_s;
        end
        grant_idx = add_mod(start, off_s);
        if (any_req) begin
            grant = ONE_HOT0 << grant_idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrated mux with a single registered output stage and valid/ready handshake.
// Supports fixed-priority and round-robin arbitration; full throughput with drain+load.
module rr_arb_mux
    import arb_pkg::*;
#(
    parameter  int        NUM_CH = 4,
    parameter  int        DATA_W = 8,
    parameter  arb_mode_e MODE   = ARB_RR,
    localparam int        IDX_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [IDX_W-1:0]         out_ch_o,
    input  logic                     out_ready_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  start_s;
    logic [IDX_W-1:0]  ptr_next_s;
    logic [NUM_CH-1:0] grant_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              any_req_s;
    logic              free_s;
    logic              load_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [DATA_W-1:0] ch_data_s [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_data_s[g] = in_data_i[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req       (in_valid_i),
        .start     (start_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_req   (any_req_s)
    );

    // Handshake and priority start; reset gates ready so nothing is accepted while cleared
    always_comb begin
        free_s     = ~out_valid_o | out_ready_i;
        load_s     = free_s & any_req_s & ~reset;
        sel_data_s = ch_data_s[grant_idx_s];
        if (MODE == ARB_RR) begin
            start_s = ptr_r;
        end else begin
            start_s = '0;
        end
        if (load_s) begin
            in_ready_o = grant_s;
        end else begin
            in_ready_o = '0;
        end
        if (grant_idx_s == LAST_IDX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Output register and round-robin pointer; pointer moves only on an accepted transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            ptr_r       <= '0;
        end else if (load_s) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_data_s;
            out_ch_o    <= grant_idx_s;
            ptr_r       <= (MODE == ARB_RR) ? ptr_next_s : ptr_r;
        end else if (free_s) begin
            out_valid_o <= 1'b0;
        end else begin
            out_valid_o <= out_valid_o;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (RR/4ch/8b, FIXED/4ch/8b, RR/3ch/16b) share stimulus;
// a reference arbiter model pushes expected words to per-instance queues, popped on drain.
module tb_rr_arb_mux;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vld;
    logic        rdy;
    logic [7:0]  d8  [4];
    logic [15:0] d16 [3];
    logic [31:0] bus_a;
    logic [47:0] bus_c;

    logic [3:0]  rdy_a, rdy_b;
    logic [2:0]  rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [7:0]  od_a, od_b;
    logic [15:0] od_c;
    logic [1:0]  oc_a, oc_b, oc_c;

    int err_cnt = 0;
    int chk_cnt = 0;

    int m_n  [3] = '{4, 4, 3};
    int m_rr [3] = '{1, 0, 1};
    int m_ptr[3];
    bit m_v  [3];
    logic [19:0] q_a[$];
    logic [19:0] q_b[$];
    logic [19:0] q_c[$];

    always #5 clk = ~clk;

    assign bus_a = {d8[3], d8[2], d8[1], d8[0]};
    assign bus_c = {d16[2], d16[1], d16[0]};

    rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .MODE(ARB_RR)) dut_a (
        .clk(clk), .reset(reset), .in_valid_i(vld), .in_data_i(bus_a), .in_ready_o(rdy_a),
        .out_valid_o(ov_a), .out_data_o(od_a), .out_ch_o(oc_a), .out_ready_i(rdy));

    rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .MODE(ARB_FIXED)) dut_b (
        .clk(clk), .reset(reset), .in_valid_i(vld), .in_data_i(bus_a), .in_ready_o(rdy_b),
        .out_valid_o(ov_b), .out_data_o(od_b), .out_ch_o(oc_b), .out_ready_i(rdy));

    rr_arb_mux #(.NUM_CH(3), .DATA_W(16), .MODE(ARB_RR)) dut_c (
        .clk(clk), .reset(reset), .in_valid_i(vld[2:0]), .in_data_i(bus_c), .in_ready_o(rdy_c),
        .out_valid_o(ov_c), .out_data_o(od_c), .out_ch_o(oc_c), .out_ready_i(rdy));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            if (req[(start + i) % n]) return (start + i) % n;
        end
        return -1;
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic logic [19:0] sb_front(input int k);
        case (k)
            0: return q_a[0];
            1: return q_b[0];
            default: return q_c[0];
        endcase
    endfunction

    task automatic sb_pop(input int k);
        case (k)
            0: void'(q_a.pop_front());
            1: void'(q_b.pop_front());
            default: void'(q_c.pop_front());
        endcase
    endtask

    task automatic sb_push(input int k, input logic [19:0] item);
        case (k)
            0: q_a.push_back(item);
            1: q_b.push_back(item);
            default: q_c.push_back(item);
        endcase
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ptr[k] = 0;
            m_v[k]   = 1'b0;
        end
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    // Called at a negedge with inputs applied; checks, advances the model, returns at next negedge
    task automatic step();
        int          w;
        bit          free;
        logic [3:0]  req, exp_rdy, act_rdy, act_ch;
        logic        act_v;
        logic [15:0] act_d, new_d;
        logic [19:0] front;
        #1;
        check_val("ptr_a", {30'd0, dut_a.ptr_r}, m_ptr[0]);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin act_rdy = rdy_a; act_v = ov_a; act_d = {8'h00, od_a}; act_ch = {2'b00, oc_a}; end
                1: begin act_rdy = rdy_b; act_v = ov_b; act_d = {8'h00, od_b}; act_ch = {2'b00, oc_b}; end
                default: begin act_rdy = {1'b0, rdy_c}; act_v = ov_c; act_d = od_c; act_ch = {2'b00, oc_c}; end
            endcase
            req     = (m_n[k] == 3) ? (vld & 4'b0111) : vld;
            w       = pick(req, (m_rr[k] != 0) ? m_ptr[k] : 0, m_n[k]);
            free    = !m_v[k] || rdy;
            exp_rdy = (free && w >= 0) ? (4'b0001 << w) : 4'b0000;
            check_val($sformatf("in_ready[%0d]", k), {28'd0, act_rdy}, {28'd0, exp_rdy});
            check_val($sformatf("out_valid[%0d]", k), {31'd0, act_v}, {31'd0, m_v[k]});
            if (m_v[k]) begin
                if (sb_size(k) == 0) begin
                    check_val($sformatf("sb_empty[%0d]", k), 32'd0, 32'd1);
                end else begin
                    front = sb_front(k);
                    check_val($sformatf("out_ch[%0d]", k), {28'd0, act_ch}, {28'd0, front[19:16]});
                    check_val($sformatf("out_data[%0d]", k), {16'd0, act_d}, {16'd0, front[15:0]});
                    if (rdy) sb_pop(k);
                end
            end
            if (free && w >= 0) begin
                new_d = (k < 2) ? {8'h00, d8[w]} : d16[w];
                sb_push(k, {w[3:0], new_d});
                m_v[k] = 1'b1;
                if (m_rr[k] != 0) m_ptr[k] = (w + 1) % m_n[k];
            end else if (free) begin
                m_v[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) d8[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) d16[i] = 16'($urandom);
    endtask

    initial begin
        logic [7:0] held;
        reset = 1'b1;
        vld   = 4'b1111;
        rdy   = 1'b1;
        rand_data();
        #3;
        check_val("rst_ready_a", {28'd0, rdy_a}, 32'd0);
        check_val("rst_valid_a", {31'd0, ov_a}, 32'd0);
        check_val("rst_ready_c", {29'd0, rdy_c}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // All requesting with a free sink: RR walks 0,1,2,3,0; FIXED stays on channel 0
        for (int c = 0; c < 6; c++) begin
            vld = 4'b1111;
            rand_data();
            step();
            check_val("fixed_ch0", {30'd0, oc_b}, 32'd0);
        end

        // Wrap-around: park ptr at 1, then channels 3 and 0 request
        vld = 4'b0001; rand_data(); step();
        vld = 4'b1001; rand_data(); step();
        check_val("wrap_ch3", {30'd0, oc_a}, 32'd3);
        rand_data(); step();
        check_val("wrap_ch0", {30'd0, oc_a}, 32'd0);

        // Back-pressure on a held 8'hA5 word, then release
        vld = 4'b0100; rand_data(); d8[2] = 8'hA5; step();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vld = 4'b1111; rand_data(); step();
            check_val("bp_hold_a5", {24'd0, od_a}, 32'h0000_00A5);
        end
        rdy = 1'b1; rand_data(); step();

        // Random traffic with random stalls and dropped requests
        for (int c = 0; c < 300; c++) begin
            vld = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        // Drain: with no requests the word leaves and data holds
        rdy = 1'b1; vld = 4'b1111; rand_data(); step();
        held = od_a;
        vld = 4'b0000; step();
        step();
        check_val("idle_hold_data", {24'd0, od_a}, {24'd0, held});

        // Reset mid-cycle while a word is held
        vld = 4'b1111; rand_data(); step();
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", {31'd0, ov_a}, 32'd0);
        check_val("mid_rst_data", {24'd0, od_a}, 32'd0);
        check_val("mid_rst_ch", {30'd0, oc_a}, 32'd0);
        check_val("mid_rst_ready", {28'd0, rdy_a}, 32'd0);
        check_val("mid_rst_ptr", {30'd0, dut_a.ptr_r}, 32'd0);
        check_val("mid_rst_data_c", {16'd0, od_c}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        vld = 4'b1010; rand_data(); step();
        check_val("post_rst_ch1", {30'd0, oc_a}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter NUM_CH, default 4, number of input channels; SHALL be legal for 2..16.
REQ-002 Parameter DATA_W, default 8, data width per channel; SHALL be legal for values of 1 or more.
REQ-003 Parameter MODE, default ARB_RR, arbitration mode: ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
REQ-004 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port reset  input  1  reset, asynchronous and active-high.
REQ-006 Port in_valid_i  input  NUM_CH  per-channel request/valid.
REQ-007 Port in_data_i  input  NUM_CH*DATA_W  channel k data in bits [k*DATA_W +: DATA_W].
REQ-008 Port in_ready_o  output  NUM_CH  per-channel accept, one-hot or zero.
REQ-009 Port out_valid_o  output  1  output register holds a word.
REQ-010 Port out_data_o  output  DATA_W  registered selected data.
REQ-011 Port out_ch_o  output  $clog2(NUM_CH)  index of the channel that supplied out_data_o.
REQ-012 Port out_ready_i  input  1  downstream accept.

Function
REQ-013 Output register "free" SHALL be defined as (!out_valid_o || out_ready_i).
REQ-014 When free and at least one in_valid_i bit is set, exactly one in_ready_o bit SHALL assert combinationally, for the winning channel; otherwise in_ready_o SHALL be 0.
REQ-015 On a rising edge with a winner, out_data_o, out_ch_o and out_valid_o=1 SHALL load from the winner; latency in_valid_i to out_valid_o is 1 cycle.
REQ-016 On a rising edge when free with no request, out_valid_o SHALL go to 0; out_data_o and out_ch_o SHALL hold their values.
REQ-017 When out_valid_o=1 and out_ready_i=0, out_data_o, out_ch_o and out_valid_o SHALL hold and in_ready_o SHALL be 0 (back-pressure).
REQ-018 Simultaneous drain and load in the same cycle SHALL be supported, for a throughput of one word per cycle.
REQ-019 ARB_FIXED: the winner SHALL be the lowest-index requesting channel (channel 0 highest priority).
REQ-020 ARB_RR: a pointer ptr SHALL give highest priority to channel ptr, then ptr+1, and so on modulo NUM_CH; the winner SHALL be the first requesting channel in that order.
REQ-021 ARB_RR: ptr SHALL update to (winner+1) mod NUM_CH only on an accepted transfer; with winner NUM_CH-1, ptr SHALL wrap to 0.
REQ-022 ARB_RR: ptr SHALL hold when there is no grant or during back-pressure.
REQ-023 A requester SHALL NOT wait more than NUM_CH-1 grants in ARB_RR.
REQ-024 The arbiter SHALL not depend on in_valid_i staying stable; a request dropped before it is granted SHALL simply lose eligibility.
REQ-025 ptr and out_ch_o arithmetic SHALL be $clog2(NUM_CH) bits wide, with an explicit modulo compare for NUM_CH values that are not powers of two.

Reset
REQ-026 While reset=1, out_valid_o SHALL be 0, out_data_o 0, out_ch_o 0, ptr 0, and in_ready_o 0, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard the held word with no handshake; the first grant after reset release SHALL follow ptr=0 priority.

Structure
REQ-028 The package arb_pkg SHALL hold the enum arb_mode_e {ARB_FIXED, ARB_RR}; rr_arb_mux SHALL import it.
REQ-029 The sub-module rr_pick SHALL compute the one-hot first-set index from a request vector and a start index (rotate, find-first, unrotate); fixed mode SHALL use start index 0.
REQ-030 The block SHALL contain only one register stage and no FIFO.

Verification
REQ-031 Reset: assert reset with out_valid_o=1 mid-cycle -> all outputs 0 immediately, and after release in_valid_i=4'b1010 grants channel 1 first.
REQ-032 Fixed mode, NUM_CH=4: in_valid_i=4'b1111 held, out_ready_i=1 -> channel 0 granted every cycle and out_ch_o stays 0.
REQ-033 RR mode, NUM_CH=4: in_valid_i=4'b1111 held, out_ready_i=1 -> out_ch_o sequence 0,1,2,3,0 on consecutive cycles with out_valid_o continuously 1.
REQ-034 RR mode: in_valid_i=4'b1001, ptr=1 -> channel 3 wins, then channel 0, so wrap-around is checked.
REQ-035 Back-pressure: out_valid_o=1 and out_ready_i=0 for 3 cycles with data 8'hA5 -> out_data_o stays 8'hA5, in_ready_o=0 and ptr unchanged; release -> next grant in the same cycle.
REQ-036 NUM_CH=3, DATA_W=16, RR mode, all requesting -> out_ch_o sequence 0,1,2,0, and a scoreboard matches every out_data_o to the granted in_data_i.
